morse_key_receiver: RTL and testbench

//  Receive side of the Morse link: times one straight-key line (pressed=1) and turns mark/space durations into
//  dot/dash symbols, then into a character code {morse_code,morse_len} for morse_decoder, plus word-space events.

---
 rtl/morse_key_receiver_pkg.sv | 25 ++
 rtl/morse_key_receiver_ms_tick_gen.sv | 32 +++
 rtl/morse_key_receiver.sv | 189 ++++++++++++++++++
 tb/tb_morse_key_receiver.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_key_receiver_pkg.sv
// Shared definitions for the Morse key receiver.
//   state_t       : receiver FSM state encoding
//   MORSE_MAX_LEN : longest character accepted (symbols)
//   SYM_DOT/DASH  : symbol encoding inside morse_code
//   sat_inc16     : 16-bit saturating increment used by the ms counters
package morse_key_receiver_pkg;

   typedef enum logic [2:0] {
      ST_ARM  = 3'd0,
      ST_IDLE = 3'd1,
      ST_MARK = 3'd2,
      ST_GAP  = 3'd3,
      ST_WGAP = 3'd4
   } state_t;

   localparam int   MORSE_MAX_LEN = 5;
   localparam logic SYM_DOT       = 1'b0;
   localparam logic SYM_DASH      = 1'b1;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
      if (en && (v != 16'hFFFF)) return v + 16'd1;
      return v;
   endfunction

endpackage

// File: rtl/morse_key_receiver_ms_tick_gen.sv
// Millisecond tick generator.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   tick : 1-cycle pulse every CLKS_PER_MS clocks
module ms_tick_gen #(
   parameter int CLKS_PER_MS = 1000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int            CW     = $clog2(CLKS_PER_MS + 1);
   localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_MS - 1);

   logic [CW-1:0] cnt;

   // Down-counter; terminal count reloads and fires the tick.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= RELOAD;
         tick <= 1'b0;
      end else if (cnt == '0) begin
         cnt  <= RELOAD;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt - 1'b1;
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/morse_key_receiver.sv
// Straight-key Morse receiver: times key marks/spaces into dot/dash symbols,
// assembles characters {morse_code, morse_len} and flags word spaces.
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   key         : raw key, asynchronous, 1 = pressed
//   morse_code  : symbols (1 = dash), newest in bit 0
//   morse_len   : symbol count 1..5
//   code_valid  : pulse, character complete
//   code_err    : pulse, character had more than 5 symbols
//   space_valid : pulse, word gap detected
//   sym_valid   : pulse per accepted symbol
//   sym_dash    : type of last accepted symbol
//   key_active  : filtered key level
//
// state | meaning
// ARM   | after reset, waiting for the key to be released
// IDLE  | no partial character
// MARK  | key pressed, timing the mark
// GAP   | key released inside a character, timing the space
// WGAP  | character emitted, waiting for a word gap
module morse_key_receiver
   import morse_key_receiver_pkg::*;
#(
   parameter int CLKS_PER_MS  = 1000,
   parameter int MIN_PRESS_MS = 20,
   parameter int DASH_MIN_MS  = 200,
   parameter int CHAR_GAP_MS  = 300,
   parameter int WORD_GAP_MS  = 700
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key,
   output logic [4:0] morse_code,
   output logic [2:0] morse_len,
   output logic       code_valid,
   output logic       code_err,
   output logic       space_valid,
   output logic       sym_valid,
   output logic       sym_dash,
   output logic       key_active
);

   localparam logic [15:0] MIN_P  = 16'(MIN_PRESS_MS);
   localparam logic [15:0] DASH_P = 16'(DASH_MIN_MS);
   localparam logic [15:0] CHAR_P = 16'(CHAR_GAP_MS);
   localparam logic [15:0] WORD_P = 16'(WORD_GAP_MS);
   localparam logic [2:0]  MAX_L  = 3'(MORSE_MAX_LEN);

   logic        tick;
   logic        key_m, key_s;
   state_t      state, ret_state;
   logic [15:0] mark_ms, gap_ms;
   logic [15:0] mark_inc, gap_inc;
   logic [15:0] tick_ms;
   logic [4:0]  code_sr;
   logic [2:0]  len_cnt;
   logic        ovf;
   logic        is_dash;

   ms_tick_gen #(.CLKS_PER_MS(CLKS_PER_MS)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign mark_inc = sat_inc16(mark_ms, tick);
   assign gap_inc  = sat_inc16(gap_ms, tick);
   assign tick_ms  = {15'd0, tick};
   assign is_dash  = (mark_ms >= DASH_P);

   // The synchronizer resets to "pressed" so a key held through reset keeps
   // ARM waiting until a real release is seen.
   // Counters restart at the current tick so an N ms interval always
   // counts exactly N ticks regardless of tick phase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_m       <= 1'b1;
         key_s       <= 1'b1;
         state       <= ST_ARM;
         ret_state   <= ST_IDLE;
         mark_ms     <= '0;
         gap_ms      <= '0;
         code_sr     <= '0;
         len_cnt     <= '0;
         ovf         <= 1'b0;
         morse_code  <= '0;
         morse_len   <= '0;
         code_valid  <= 1'b0;
         code_err    <= 1'b0;
         space_valid <= 1'b0;
         sym_valid   <= 1'b0;
         sym_dash    <= 1'b0;
         key_active  <= 1'b0;
      end else begin
         key_m       <= key;
         key_s       <= key_m;
         code_valid  <= 1'b0;
         code_err    <= 1'b0;
         space_valid <= 1'b0;
         sym_valid   <= 1'b0;
         key_active  <= 1'b0;
         mark_ms     <= mark_inc;
         gap_ms      <= gap_inc;

         case (state)
            ST_ARM: begin
               if (!key_s) state <= ST_IDLE;
            end

            ST_IDLE: begin
               if (key_s) begin
                  ret_state <= ST_IDLE;
                  mark_ms   <= tick_ms;
                  state     <= ST_MARK;
               end
            end

            ST_MARK: begin
               if (key_s) begin
                  key_active <= (mark_inc >= MIN_P);
               end else if (mark_ms < MIN_P) begin
                  // Glitch: gap_ms has kept running underneath.
                  state <= ret_state;
               end else begin
                  sym_valid <= 1'b1;
                  sym_dash  <= is_dash;
                  gap_ms    <= tick_ms;
                  state     <= ST_GAP;
                  if (len_cnt == MAX_L) begin
                     ovf <= 1'b1;
                  end else begin
                     code_sr    <= {code_sr[3:0], is_dash};
                     len_cnt    <= len_cnt + 3'd1;
                     morse_code <= {code_sr[3:0], is_dash};
                     morse_len  <= len_cnt + 3'd1;
                  end
               end
            end

            ST_GAP: begin
               if (gap_inc >= CHAR_P) begin
                  if (ovf) begin
                     code_err <= 1'b1;
                  end else begin
                     code_valid <= 1'b1;
                     morse_code <= code_sr;
                     morse_len  <= len_cnt;
                  end
                  code_sr <= '0;
                  len_cnt <= '0;
                  ovf     <= 1'b0;
                  // A press on the emission cycle opens the next character.
                  if (key_s) begin
                     ret_state <= ST_WGAP;
                     mark_ms   <= tick_ms;
                     state     <= ST_MARK;
                  end else begin
                     state <= ST_WGAP;
                  end
               end else if (key_s) begin
                  ret_state <= ST_GAP;
                  mark_ms   <= tick_ms;
                  state     <= ST_MARK;
               end
            end

            ST_WGAP: begin
               if (gap_inc >= WORD_P) begin
                  space_valid <= 1'b1;
                  if (key_s) begin
                     ret_state <= ST_IDLE;
                     mark_ms   <= tick_ms;
                     state     <= ST_MARK;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else if (key_s) begin
                  ret_state <= ST_WGAP;
                  mark_ms   <= tick_ms;
                  state     <= ST_MARK;
               end
            end

            default: state <= ST_ARM;
         endcase
      end
   end

endmodule

// File: tb/tb_morse_key_receiver.sv
module tb_morse_key_receiver;

   localparam int C   = 4;
   localparam int TOL = C + 3;

   localparam int EV_SYM   = 0;
   localparam int EV_CODE  = 1;
   localparam int EV_ERR   = 2;
   localparam int EV_SPACE = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key = 1'b0;
   logic [4:0] morse_code;
   logic [2:0] morse_len;
   logic       code_valid, code_err, space_valid, sym_valid, sym_dash, key_active;

   int unsigned cyc = 0;
   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int          kind;
      logic [4:0]  code;
      logic [2:0]  len;
      int unsigned at;
   } ev_t;

   ev_t exp_q[$];

   morse_key_receiver #(
      .CLKS_PER_MS (C),
      .MIN_PRESS_MS(20),
      .DASH_MIN_MS (200),
      .CHAR_GAP_MS (300),
      .WORD_GAP_MS (700)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key        (key),
      .morse_code (morse_code),
      .morse_len  (morse_len),
      .code_valid (code_valid),
      .code_err   (code_err),
      .space_valid(space_valid),
      .sym_valid  (sym_valid),
      .sym_dash   (sym_dash),
      .key_active (key_active)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops the scoreboard whenever the DUT pulses an output.
   always @(negedge clk) begin
      ev_t e;
      int  hits;
      int  kind;
      logic [4:0] code;
      logic [2:0] len;
      int  d;
      if (rst) begin
         hits = int'(sym_valid) + int'(code_valid) + int'(code_err) + int'(space_valid);
         if (hits > 1) begin
            n_checks++;
            n_fail++;
            $display("FAIL overlap at cyc %0d: sym=%b code=%b err=%b space=%b, required at most one",
                     cyc, sym_valid, code_valid, code_err, space_valid);
         end else if (hits == 1) begin
            n_checks++;
            code = '0;
            len  = '0;
            if (sym_valid) begin
               kind = EV_SYM;
               code = {4'b0, sym_dash};
            end else if (code_valid) begin
               kind = EV_CODE;
               code = morse_code;
               len  = morse_len;
            end else if (code_err) begin
               kind = EV_ERR;
            end else begin
               kind = EV_SPACE;
            end
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_event at cyc %0d: got kind=%0d code=%b len=%0d, required none",
                        cyc, kind, code, len);
            end else begin
               e = exp_q.pop_front();
               d = int'(cyc) - int'(e.at);
               if (kind != e.kind || code != e.code || len != e.len || d < -TOL || d > TOL) begin
                  n_fail++;
                  $display("FAIL event at cyc %0d: got kind=%0d code=%b len=%0d, required kind=%0d code=%b len=%0d near cyc %0d",
                           cyc, kind, code, len, e.kind, e.code, e.len, e.at);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic push(input int kind, input logic [4:0] code, input logic [2:0] len,
                       input int unsigned at);
      ev_t e;
      e.kind = kind;
      e.code = code;
      e.len  = len;
      e.at   = at;
      exp_q.push_back(e);
   endtask

   task automatic wait_ms(input int ms);
      repeat (ms * C) @(negedge clk);
   endtask

   task automatic press(input int ms);
      key = 1'b1;
      wait_ms(ms);
   endtask

   task automatic rel(input int ms);
      key = 1'b0;
      wait_ms(ms);
   endtask

   // Releases the key and schedules the resulting symbol.
   task automatic release_sym(input logic dash, output int unsigned r);
      r = cyc;
      push(EV_SYM, {4'b0, dash}, 3'd0, r + 3);
      key = 1'b0;
   endtask

   task automatic push_char(input int kind, input logic [4:0] code, input logic [2:0] len,
                            input int unsigned r);
      push(kind, code, len, r + 3 + 300 * C);
      push(EV_SPACE, 5'd0, 3'd0, r + 3 + 700 * C);
   endtask

   function automatic logic [15:0] all_outs();
      return {2'b00, morse_code, morse_len, code_valid, code_err, space_valid,
              sym_valid, sym_dash, key_active};
   endfunction

   initial begin
      int unsigned r;

      rst = 1'b0;
      key = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_outputs", all_outs(), 16'h0000);
      rst = 1'b1;
      wait_ms(5);

      // 'A': dot then dash
      press(80);
      release_sym(1'b0, r);
      rel(100);
      press(5);
      check("key_active_early", {15'd0, key_active}, 16'd0);
      press(295);
      check("key_active_held", {15'd0, key_active}, 16'd1);
      release_sym(1'b1, r);
      push_char(EV_CODE, 5'b00001, 3'd2, r);
      rel(800);

      // 'E' with a long idle afterwards: exactly one space
      press(80);
      release_sym(1'b0, r);
      push_char(EV_CODE, 5'b00000, 3'd1, r);
      rel(1000);

      // six dots overflow, then a fresh single-dot character
      for (int i = 0; i < 6; i++) begin
         press(80);
         release_sym(1'b0, r);
         if (i < 5) begin
            rel(100);
         end else begin
            push_char(EV_ERR, 5'd0, 3'd0, r);
            rel(800);
         end
      end
      press(80);
      release_sym(1'b0, r);
      push_char(EV_CODE, 5'b00000, 3'd1, r);
      rel(800);

      // glitch in IDLE, then glitch mid-GAP must not restart the gap
      press(10);
      rel(100);
      press(80);
      release_sym(1'b0, r);
      push_char(EV_CODE, 5'b00000, 3'd1, r);
      rel(100);
      press(10);
      rel(700);

      // dot/dash threshold and glitch threshold
      press(199);
      release_sym(1'b0, r);
      rel(100);
      press(200);
      release_sym(1'b1, r);
      push_char(EV_CODE, 5'b00001, 3'd2, r);
      rel(800);
      press(19);
      rel(100);
      press(20);
      release_sym(1'b0, r);
      push_char(EV_CODE, 5'b00000, 3'd1, r);
      rel(800);

      // reset while the key is held
      press(80);
      check("key_active_before_rst", {15'd0, key_active}, 16'd1);
      rst = 1'b0;
      #1;
      check("outputs_in_reset", all_outs(), 16'h0000);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      press(50);
      check("key_active_after_rst", {15'd0, key_active}, 16'd0);
      rel(800);
      press(80);
      release_sym(1'b0, r);
      push_char(EV_CODE, 5'b00000, 3'd1, r);
      rel(800);

      check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
